// File: rtl/id_hazard_stage.sv
// Decode stage: regfile with write-through, N-channel forwarding, load-use stall,
// early branch resolution and an elastic valid/ready ID/EX register.
module id_hazard_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NBYP   = 3,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-3:0]        in_pcp1,
    input  logic [31:0]            in_instr,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic                   rs_used,
    input  logic                   rt_used,
    input  logic [2:0]             br_type,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_rw,
    input  logic [XLEN-1:0]        wb_wd,
    input  logic [NBYP-1:0]        byp_valid,
    input  logic [NBYP-1:0]        byp_pend,
    input  logic [NBYP*AW-1:0]     byp_rw,
    input  logic [NBYP*XLEN-1:0]   byp_wd,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [XLEN-3:0]        out_pcp1,
    output logic [31:0]            out_instr,
    output logic [XLEN-1:0]        out_rd1,
    output logic [XLEN-1:0]        out_rd2,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic                   redirect,
    output logic [XLEN-3:0]        redirect_pc,
    output logic [CNT_W-1:0]       stall_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   rs_addr, rt_addr;
    logic [XLEN-1:0] rd1, rd2;
    logic            pend1, pend2;
    logic            hazard, taken;
    logic [XLEN-3:0] imm_ext;

    assign rs_addr = AW'(in_instr[25:21]);
    assign rt_addr = AW'(in_instr[20:16]);

    // Returns {pending, data}; the loop runs oldest-first so channel 0 overrides.
    function automatic logic [XLEN:0] pick(
        input logic [AW-1:0]        a,
        input logic [XLEN-1:0]      rf_val,
        input logic                 we,
        input logic [AW-1:0]        rw,
        input logic [XLEN-1:0]      wd,
        input logic [NBYP-1:0]      bv,
        input logic [NBYP-1:0]      bp,
        input logic [NBYP*AW-1:0]   brw,
        input logic [NBYP*XLEN-1:0] bwd
    );
        logic [XLEN-1:0] d;
        logic            p;
        d = rf_val;
        p = 1'b0;
        if (we && rw == a) d = wd;
        for (int i = NBYP - 1; i >= 0; i--) begin
            if (bv[i] && brw[i*AW +: AW] == a) begin
                d = bwd[i*XLEN +: XLEN];
                p = bp[i];
            end
        end
        if (a == '0) begin
            d = '0;
            p = 1'b0;
        end
        return {p, d};
    endfunction

    always_comb begin
        {pend1, rd1} = pick(rs_addr, regs[rs_addr], wb_we, wb_rw, wb_wd,
                            byp_valid, byp_pend, byp_rw, byp_wd);
        {pend2, rd2} = pick(rt_addr, regs[rt_addr], wb_we, wb_rw, wb_wd,
                            byp_valid, byp_pend, byp_rw, byp_wd);
    end

    assign hazard   = in_valid & ~flush & ((rs_used & pend1) | (rt_used & pend2));
    assign in_ready = flush | (~hazard & (~out_valid | out_ready));

    always_comb begin
        taken = 1'b0;
        case (br_type)
            3'd1:    taken = (rd1 == rd2);
            3'd2:    taken = (rd1 != rd2);
            3'd3:    taken = rd1[XLEN-1] | (rd1 == '0);
            3'd4:    taken = ~rd1[XLEN-1] & (rd1 != '0);
            3'd5:    taken = rd1[XLEN-1];
            3'd6:    taken = ~rd1[XLEN-1];
            default: taken = 1'b0;
        endcase
    end

    assign imm_ext     = {{(XLEN-18){in_instr[15]}}, in_instr[15:0]};
    assign redirect_pc = in_pcp1 + imm_ext;
    assign redirect    = in_valid & in_ready & ~flush & taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_rw != '0) begin
            regs[wb_rw] <= wb_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pcp1  <= '0;
            out_instr <= '0;
            out_rd1   <= '0;
            out_rd2   <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_pcp1  <= in_pcp1;
            out_instr <= in_instr;
            out_rd1   <= rd1;
            out_rd2   <= rd2;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage: driver pushes expected ID/EX contents,
// a negedge monitor pops them on every out_valid & out_ready transfer.
module tb_id_hazard_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NBYP = 3;
    localparam int EW   = (XLEN-2) + 32 + XLEN + XLEN + 32;

    logic                 clk, rst;
    logic                 in_valid, in_ready;
    logic [XLEN-3:0]      in_pcp1;
    logic [31:0]          in_instr;
    logic [31:0]          in_ctrl;
    logic                 rs_used, rt_used;
    logic [2:0]           br_type;
    logic                 wb_we;
    logic [AW-1:0]        wb_rw;
    logic [XLEN-1:0]      wb_wd;
    logic [NBYP-1:0]      byp_valid, byp_pend;
    logic [NBYP*AW-1:0]   byp_rw;
    logic [NBYP*XLEN-1:0] byp_wd;
    logic                 flush, out_ready, out_valid;
    logic [XLEN-3:0]      out_pcp1;
    logic [31:0]          out_instr;
    logic [XLEN-1:0]      out_rd1, out_rd2;
    logic [31:0]          out_ctrl;
    logic                 redirect;
    logic [XLEN-3:0]      redirect_pc;
    logic [15:0]          stall_cnt;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    id_hazard_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pcp1(in_pcp1), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .rs_used(rs_used), .rt_used(rt_used), .br_type(br_type),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_wd(wb_wd),
        .byp_valid(byp_valid), .byp_pend(byp_pend), .byp_rw(byp_rw), .byp_wd(byp_wd),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_pcp1(out_pcp1), .out_instr(out_instr), .out_rd1(out_rd1),
        .out_rd2(out_rd2), .out_ctrl(out_ctrl), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver helpers
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0; in_pcp1 = '0; in_instr = '0; in_ctrl = '0;
        rs_used = 0; rt_used = 0; br_type = '0;
        wb_we = 0; wb_rw = '0; wb_wd = '0;
        byp_valid = '0; byp_pend = '0; byp_rw = '0; byp_wd = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic set_byp(input int ch, input logic v, input logic p,
                           input logic [4:0] r, input logic [31:0] d);
        byp_valid[ch]          = v;
        byp_pend[ch]           = p;
        byp_rw[ch*AW +: AW]    = r;
        byp_wd[ch*XLEN +: XLEN] = d;
    endtask

    task automatic set_wb(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1; wb_rw = r; wb_wd = d;
    endtask

    task automatic issue(input logic [29:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [2:0] bt);
        in_valid = 1;
        in_pcp1  = pc;
        in_instr = {6'h04, rs, rt, imm};
        in_ctrl  = {2'b0, pc} ^ 32'hC0DE_0000;
        rs_used  = 1;
        rt_used  = 1;
        br_type  = bt;
    endtask

    task automatic push_exp(input logic [31:0] rd1, input logic [31:0] rd2);
        exp_q.push_back({in_pcp1, in_instr, rd1, rd2, in_ctrl});
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected: got pcp1=%0h with no expected entry", out_pcp1);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_pcp1, out_instr, out_rd1, out_rd2, out_ctrl} !== e) begin
                        n_bad++;
                        $display("FAIL out_slot: got %0h expected %0h",
                                 {out_pcp1, out_instr, out_rd1, out_rd2, out_ctrl}, e);
                    end
                end
            end
        end
    end

    // directed stimulus
    initial begin
        clr();
        rst = 1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_stall_cnt", 64'(stall_cnt), 0);
        chk("reset_out_rd1", 64'(out_rd1), 0);
        tick();
        rst = 0;

        // write-through on r3
        clr(); issue(30'h10, 5'd3, 5'd0, 16'h0, 3'd0); set_wb(5'd3, 32'hDEADBEEF);
        @(negedge clk); chk("wt_in_ready", 64'(in_ready), 1); push_exp(32'hDEADBEEF, 0);
        tick();
        // r0 write ignored; r3 now from regfile
        clr(); issue(30'h11, 5'd0, 5'd3, 16'h0, 3'd0); set_wb(5'd0, 32'h5);
        @(negedge clk); push_exp(0, 32'hDEADBEEF);
        tick();
        clr(); set_wb(5'd5, 32'h55);
        tick();

        // forwarding priority
        clr(); issue(30'h12, 5'd4, 5'd5, 16'h0, 3'd0);
        set_byp(0, 1, 0, 5'd4, 32'h11); set_byp(2, 1, 0, 5'd4, 32'h33); set_wb(5'd4, 32'h44);
        @(negedge clk); push_exp(32'h11, 32'h55);
        tick();
        set_byp(0, 0, 0, 5'd4, 32'h11); in_pcp1 = 30'h13; in_ctrl = 32'h13;
        @(negedge clk); push_exp(32'h33, 32'h55);
        tick();
        clr(); issue(30'h14, 5'd4, 5'd5, 16'h0, 3'd0); set_wb(5'd4, 32'h45);
        @(negedge clk); push_exp(32'h45, 32'h55);
        tick();

        // load-use stall
        clr(); issue(30'h20, 5'd0, 5'd7, 16'h0, 3'd0); set_byp(0, 1, 1, 5'd7, 32'h0BAD);
        @(negedge clk);
        chk("lu_in_ready", 64'(in_ready), 0);
        chk("lu_redirect", 64'(redirect), 0);
        tick();
        set_byp(0, 1, 0, 5'd7, 32'h99);
        @(negedge clk);
        chk("lu_stall_cnt", 64'(stall_cnt), 1);
        chk("lu_bubble", 64'(out_valid), 0);
        chk("lu_resume_ready", 64'(in_ready), 1);
        push_exp(0, 32'h99);
        tick();
        // younger non-pending match masks older pending one
        clr(); issue(30'h21, 5'd0, 5'd7, 16'h0, 3'd0);
        set_byp(0, 1, 0, 5'd7, 32'h77); set_byp(1, 1, 1, 5'd7, 32'h0BAD);
        @(negedge clk);
        chk("mask_in_ready", 64'(in_ready), 1);
        push_exp(0, 32'h77);
        tick();
        chk("mask_stall_cnt", 64'(stall_cnt), 1);

        // branches
        clr(); issue(30'h100, 5'd8, 5'd9, 16'hFFFE, 3'd1);
        set_byp(0, 1, 0, 5'd8, 32'h10); set_byp(1, 1, 0, 5'd9, 32'h10);
        @(negedge clk);
        chk("beq_redirect", 64'(redirect), 1);
        chk("beq_target", 64'(redirect_pc), 64'hFE);
        push_exp(32'h10, 32'h10);
        tick();
        set_byp(0, 1, 1, 5'd8, 32'h10); in_pcp1 = 30'h100;
        @(negedge clk);
        chk("beq_pend_redirect", 64'(redirect), 0);
        chk("beq_pend_ready", 64'(in_ready), 0);
        tick();
        set_byp(0, 1, 0, 5'd8, 32'h10);
        @(negedge clk);
        chk("beq_pend_cnt", 64'(stall_cnt), 2);
        chk("beq_resolved", 64'(redirect), 1);
        push_exp(32'h10, 32'h10);
        tick();
        br_type = 3'd2;
        @(negedge clk); chk("bne_not_taken", 64'(redirect), 0); push_exp(32'h10, 32'h10);
        tick();
        br_type = 3'd5; set_byp(0, 1, 0, 5'd8, 32'h8000_0000);
        @(negedge clk); chk("bltz_taken", 64'(redirect), 1); push_exp(32'h8000_0000, 32'h10);
        tick();
        clr(); issue(30'h3FFF_FFFF, 5'd0, 5'd0, 16'h0001, 3'd1);
        @(negedge clk);
        chk("wrap_redirect", 64'(redirect), 1);
        chk("wrap_target", 64'(redirect_pc), 0);
        push_exp(0, 0);
        tick();

        // back-pressure
        clr(); issue(30'h200, 5'd3, 5'd0, 16'h0, 3'd0);
        @(negedge clk); push_exp(32'hDEADBEEF, 0);
        tick();
        clr(); issue(30'h201, 5'd0, 5'd0, 16'h0, 3'd0); out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 0);
            chk("bp_hold_valid", 64'(out_valid), 1);
            chk("bp_hold_pcp1", 64'(out_pcp1), 64'h200);
            tick();
        end
        out_ready = 1;
        @(negedge clk); chk("bp_release_ready", 64'(in_ready), 1); push_exp(0, 0);
        tick();

        // flush beats hazard
        clr(); issue(30'h300, 5'd0, 5'd7, 16'h0, 3'd1); set_byp(0, 1, 1, 5'd7, 32'h1);
        flush = 1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 1);
        chk("flush_redirect", 64'(redirect), 0);
        tick();
        clr();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 0);
        chk("flush_stall_cnt", 64'(stall_cnt), 2);
        tick();

        // reset mid-stream
        clr(); issue(30'h310, 5'd5, 5'd0, 16'h0, 3'd0);
        @(negedge clk); push_exp(32'h55, 0);
        tick();
        clr();
        rst = 1;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_stall_cnt", 64'(stall_cnt), 0);
        #2 rst = 0;
        issue(30'h311, 5'd5, 5'd0, 16'h0, 3'd0);
        @(negedge clk); push_exp(0, 0);
        tick();
        clr();
        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
